mult_reservation_station: RTL and testbench

Reservation station for the multiplier functional unit, upstream of the multiplier issue/execute stage. Holds up to `RSsize` dispatched multiply operations and captures missing operands by snooping the common data bus (CDB). Selects one fully ready entry per cycle and presents it on the issue port. The downstream stage's stall signal qualifies the transfer.

---
 rtl/rs_pkg.sv | 27 ++
 rtl/mult_reservation_station_if.sv | 45 ++++
 rtl/rs_entry.sv | 51 +++++
 rtl/mult_reservation_station.sv | 144 ++++++++++++++
 tb/tb_mult_reservation_station.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/rs_pkg.sv
// Shared types and constants for the multiplier reservation station.
// Optional feature macro: RS_AGE_SELECT_EN (adds per-entry age for oldest-first select).
package rs_pkg;

  localparam int RS_CMD_W = 10;
  localparam int RS_VAL_W = 64;
  // Widest ROB tag an entry can carry; narrower tags are zero-extended.
  localparam int RS_TAG_W = 8;
  // Wide enough for an age in a station of up to 8 entries.
  localparam int RS_AGE_W = 3;

  typedef struct packed {
    logic                busy;
    logic [RS_CMD_W-1:0] cmd;
    logic [RS_TAG_W-1:0] tag;
    logic [RS_VAL_W-1:0] val1;
    logic                rdy1;
    logic [RS_TAG_W-1:0] src1;
    logic [RS_VAL_W-1:0] val2;
    logic                rdy2;
    logic [RS_TAG_W-1:0] src2;
`ifdef RS_AGE_SELECT_EN
    logic [RS_AGE_W-1:0] age;
`endif
  } rs_entry_t;

endpackage

// File: rtl/mult_reservation_station_if.sv
// Dispatch / CDB / issue bus of the multiplier reservation station.
// slave = the station, master = the surrounding pipeline.
interface mult_reservation_station_if
  import rs_pkg::*;
#(
  parameter int ROBsizeLog = 5
);
  logic                  dispatchValid_i;
  logic [RS_CMD_W-1:0]   dispatchCommands_i;
  logic [ROBsizeLog-1:0] dispatchTag_i;
  logic [RS_VAL_W-1:0]   dispatchVal1_i;
  logic [RS_VAL_W-1:0]   dispatchVal2_i;
  logic                  dispatchRdy1_i;
  logic                  dispatchRdy2_i;
  logic [ROBsizeLog-1:0] dispatchSrc1_i;
  logic [ROBsizeLog-1:0] dispatchSrc2_i;
  logic                  full_o;
  logic                  cdbValid_i;
  logic [ROBsizeLog-1:0] cdbTag_i;
  logic [RS_VAL_W-1:0]   cdbVal_i;
  logic [RS_VAL_W-1:0]   reservationStationVal1_o;
  logic [RS_VAL_W-1:0]   reservationStationVal2_o;
  logic [RS_CMD_W-1:0]   reservationStationCommands_o;
  logic [ROBsizeLog-1:0] reservationStationTag_o;
  logic                  readyRS_o;
  logic                  stallRS_i;

  modport slave (
    input  dispatchValid_i, dispatchCommands_i, dispatchTag_i,
    input  dispatchVal1_i, dispatchVal2_i, dispatchRdy1_i, dispatchRdy2_i,
    input  dispatchSrc1_i, dispatchSrc2_i,
    input  cdbValid_i, cdbTag_i, cdbVal_i, stallRS_i,
    output full_o, reservationStationVal1_o, reservationStationVal2_o,
    output reservationStationCommands_o, reservationStationTag_o, readyRS_o
  );

  modport master (
    output dispatchValid_i, dispatchCommands_i, dispatchTag_i,
    output dispatchVal1_i, dispatchVal2_i, dispatchRdy1_i, dispatchRdy2_i,
    output dispatchSrc1_i, dispatchSrc2_i,
    output cdbValid_i, cdbTag_i, cdbVal_i, stallRS_i,
    input  full_o, reservationStationVal1_o, reservationStationVal2_o,
    input  reservationStationCommands_o, reservationStationTag_o, readyRS_o
  );
endinterface

// File: rtl/rs_entry.sv
// One reservation-station entry: dispatch write, CDB snoop/wakeup, free.
// With RS_AGE_SELECT_EN the entry also keeps an age that the top decrements.
module rs_entry
  import rs_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  rs_entry_t           wr_data,
  input  logic                cdb_valid,
  input  logic [RS_TAG_W-1:0] cdb_tag,
  input  logic [RS_VAL_W-1:0] cdb_val,
  input  logic                free_en,
`ifdef RS_AGE_SELECT_EN
  input  logic                age_dec,
`endif
  output rs_entry_t           q
);

  rs_entry_t base;
  rs_entry_t nxt;

  // Next entry state; the CDB compare is shared by resident and incoming operands.
  always_comb begin
    base = wr_en ? wr_data : q;
    nxt  = base;
    if (base.busy && cdb_valid && !base.rdy1 && (cdb_tag == base.src1)) begin
      nxt.val1 = cdb_val;
      nxt.rdy1 = 1'b1;
    end
    if (base.busy && cdb_valid && !base.rdy2 && (cdb_tag == base.src2)) begin
      nxt.val2 = cdb_val;
      nxt.rdy2 = 1'b1;
    end
`ifdef RS_AGE_SELECT_EN
    if (age_dec) nxt.age = base.age - 1'b1;
`endif
    // Issue wins over a same-cycle wakeup: the entry just leaves.
    if (free_en) begin
      nxt      = q;
      nxt.busy = 1'b0;
    end
  end

  // Entry register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= nxt;
  end

endmodule

// File: rtl/mult_reservation_station.sv
// Multiplier reservation station top: free-slot find, select, issue mux.
// Optional macro RS_AGE_SELECT_EN: select oldest eligible entry instead of lowest index.
module mult_reservation_station
  import rs_pkg::*;
#(
  parameter int ROBsize    = 16,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int RSsize     = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  mult_reservation_station_if.slave  bus
);

  localparam int IDX_W = $clog2(RSsize);

  rs_entry_t               ent [RSsize];
  rs_entry_t               disp;
  rs_entry_t               sel;
  logic [RSsize-1:0]       busy_v, elig_v, wr_v, free_v;
  logic [IDX_W-1:0]        pick_idx, sel_idx, lock_idx;
  logic                    pick_valid, lock_valid, ready, accept, full, found;
  logic                    unused_bits;
`ifdef RS_AGE_SELECT_EN
  logic [RSsize-1:0]       age_dec;
  logic [RS_AGE_W:0]       busy_cnt;
  logic [RS_AGE_W-1:0]     best_age;
`endif

  for (genvar g = 0; g < RSsize; g++) begin : g_ent
    rs_entry u_entry (
      .clk       (clk_i),
      .rst       (reset_i),
      .wr_en     (wr_v[g]),
      .wr_data   (disp),
      .cdb_valid (bus.cdbValid_i),
      .cdb_tag   (RS_TAG_W'(bus.cdbTag_i)),
      .cdb_val   (bus.cdbVal_i),
      .free_en   (free_v[g]),
`ifdef RS_AGE_SELECT_EN
      .age_dec   (age_dec[g]),
`endif
      .q         (ent[g])
    );
    assign busy_v[g] = ent[g].busy;
    assign elig_v[g] = ent[g].busy & ent[g].rdy1 & ent[g].rdy2;
  end

  assign full   = &busy_v;
  assign ready  = |elig_v;
  assign accept = ready & ~bus.stallRS_i;

  // Candidate pick from registered state: lowest index, or smallest age.
  always_comb begin
    pick_idx   = '0;
    pick_valid = 1'b0;
`ifdef RS_AGE_SELECT_EN
    best_age   = '1;
    for (int unsigned i = 0; i < RSsize; i++) begin
      if (elig_v[i] && (!pick_valid || ent[i].age < best_age)) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(i);
        best_age   = ent[i].age;
      end
    end
`else
    for (int unsigned i = 0; i < RSsize; i++) begin
      if (elig_v[i] && !pick_valid) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(i);
      end
    end
`endif
  end

  // A presented-but-stalled entry is locked so later wakeups cannot displace it.
  assign sel_idx = lock_valid ? lock_idx : pick_idx;
  assign sel     = ent[sel_idx];

  // Selection lock register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock_valid <= 1'b0;
      lock_idx   <= '0;
    end else begin
      lock_valid <= ready & bus.stallRS_i;
      lock_idx   <= sel_idx;
    end
  end

  // Lowest free slot, dispatch record, issue free and age bookkeeping.
  always_comb begin
    wr_v   = '0;
    found  = 1'b0;
    free_v = '0;
    for (int unsigned i = 0; i < RSsize; i++) begin
      if (!busy_v[i] && !found) begin
        found   = 1'b1;
        wr_v[i] = bus.dispatchValid_i & ~full;
      end
    end
    free_v[sel_idx] = accept;

    disp      = '0;
    disp.busy = 1'b1;
    disp.cmd  = bus.dispatchCommands_i;
    disp.tag  = RS_TAG_W'(bus.dispatchTag_i);
    disp.val1 = bus.dispatchVal1_i;
    disp.rdy1 = bus.dispatchRdy1_i;
    disp.src1 = RS_TAG_W'(bus.dispatchSrc1_i);
    disp.val2 = bus.dispatchVal2_i;
    disp.rdy2 = bus.dispatchRdy2_i;
    disp.src2 = RS_TAG_W'(bus.dispatchSrc2_i);
`ifdef RS_AGE_SELECT_EN
    busy_cnt = '0;
    age_dec  = '0;
    for (int unsigned i = 0; i < RSsize; i++) begin
      busy_cnt   = busy_cnt + (RS_AGE_W+1)'(busy_v[i]);
      age_dec[i] = accept & busy_v[i] & (ent[i].age > sel.age);
    end
    // Newcomer is younger than every entry surviving this edge.
    disp.age = RS_AGE_W'(busy_cnt - (RS_AGE_W+1)'(accept));
`endif
  end

  // Issue outputs, forced to zero when nothing is eligible.
  always_comb begin
    bus.full_o                       = full;
    bus.readyRS_o                    = ready;
    bus.reservationStationVal1_o     = ready ? sel.val1 : '0;
    bus.reservationStationVal2_o     = ready ? sel.val2 : '0;
    bus.reservationStationCommands_o = ready ? sel.cmd  : '0;
    bus.reservationStationTag_o      = ready ? sel.tag[ROBsizeLog-1:0] : '0;
  end

  // Fields only consumed inside the entries or above the configured tag width.
  always_comb begin
    unused_bits = ^sel;
    for (int unsigned i = 0; i < RSsize; i++) begin
      unused_bits = unused_bits ^ (^{ent[i].src1, ent[i].src2, ent[i].tag});
    end
  end

endmodule

// File: tb/tb_mult_reservation_station.sv
// Self-checking bench for mult_reservation_station (directed + random).
// Honours RS_AGE_SELECT_EN in its reference model.
module tb_mult_reservation_station;
  localparam int TW = 5;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_reservation_station_if #(.ROBsizeLog(TW)) bus ();

  mult_reservation_station #(.ROBsize(16), .ROBsizeLog(TW), .RSsize(N)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  int unsigned nvec = 0;
  int unsigned nmis = 0;

  // Reference model: slots with a dispatch sequence number for age.
  bit          m_busy [N];
  logic [9:0]  m_cmd  [N];
  logic [TW-1:0] m_tag [N], m_s1 [N], m_s2 [N];
  logic [63:0] m_v1 [N], m_v2 [N];
  bit          m_r1 [N], m_r2 [N];
  int unsigned m_seq [N];
  int unsigned next_seq = 0;
  bit          m_lock = 0;
  int          m_lock_idx = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_pick();
    int best = -1;
    if (m_lock) return m_lock_idx;
    for (int i = 0; i < N; i++) begin
      if (m_busy[i] && m_r1[i] && m_r2[i]) begin
`ifdef RS_AGE_SELECT_EN
        if (best < 0 || m_seq[i] < m_seq[best]) best = i;
`else
        if (best < 0) best = i;
`endif
      end
    end
    return best;
  endfunction

  function automatic bit m_full();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_outputs();
    int p = m_pick();
    chk("ready", bus.readyRS_o, p >= 0);
    chk("full",  bus.full_o,    m_full());
    chk("val1",  bus.reservationStationVal1_o,     p >= 0 ? m_v1[p]  : 64'd0);
    chk("val2",  bus.reservationStationVal2_o,     p >= 0 ? m_v2[p]  : 64'd0);
    chk("cmd",   bus.reservationStationCommands_o, p >= 0 ? 64'(m_cmd[p]) : 64'd0);
    chk("tag",   bus.reservationStationTag_o,      p >= 0 ? 64'(m_tag[p]) : 64'd0);
  endtask

  task automatic m_update();
    int p, f;
    bit acc, full;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_busy[i] = 0; m_r1[i] = 0; m_r2[i] = 0;
      end
      m_lock = 0;
      return;
    end
    p    = m_pick();
    acc  = (p >= 0) && !bus.stallRS_i;
    full = m_full();
    f = -1;
    for (int i = N - 1; i >= 0; i--) if (!m_busy[i]) f = i;
    for (int i = 0; i < N; i++) begin
      if (m_busy[i] && bus.cdbValid_i) begin
        if (!m_r1[i] && bus.cdbTag_i == m_s1[i]) begin m_r1[i] = 1; m_v1[i] = bus.cdbVal_i; end
        if (!m_r2[i] && bus.cdbTag_i == m_s2[i]) begin m_r2[i] = 1; m_v2[i] = bus.cdbVal_i; end
      end
    end
    if (acc) m_busy[p] = 0;
    if (bus.dispatchValid_i && !full) begin
      m_busy[f] = 1;
      m_cmd[f]  = bus.dispatchCommands_i;
      m_tag[f]  = bus.dispatchTag_i;
      m_v1[f] = bus.dispatchVal1_i; m_r1[f] = bus.dispatchRdy1_i; m_s1[f] = bus.dispatchSrc1_i;
      m_v2[f] = bus.dispatchVal2_i; m_r2[f] = bus.dispatchRdy2_i; m_s2[f] = bus.dispatchSrc2_i;
      if (bus.cdbValid_i && !m_r1[f] && bus.cdbTag_i == m_s1[f]) begin m_r1[f] = 1; m_v1[f] = bus.cdbVal_i; end
      if (bus.cdbValid_i && !m_r2[f] && bus.cdbTag_i == m_s2[f]) begin m_r2[f] = 1; m_v2[f] = bus.cdbVal_i; end
      m_seq[f] = next_seq++;
    end
    m_lock     = (p >= 0) && bus.stallRS_i;
    m_lock_idx = p;
  endtask

  // Inputs are set at the falling edge; outputs checked 1 ns later.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic idle(input logic stall);
    bus.dispatchValid_i = 0; bus.dispatchCommands_i = '0; bus.dispatchTag_i = '0;
    bus.dispatchVal1_i = '0; bus.dispatchVal2_i = '0;
    bus.dispatchRdy1_i = 0;  bus.dispatchRdy2_i = 0;
    bus.dispatchSrc1_i = '0; bus.dispatchSrc2_i = '0;
    bus.cdbValid_i = 0; bus.cdbTag_i = '0; bus.cdbVal_i = '0;
    bus.stallRS_i = stall;
  endtask

  task automatic disp(input logic [TW-1:0] tag, input logic [63:0] v1, input logic r1,
                      input logic [TW-1:0] s1, input logic [63:0] v2, input logic r2,
                      input logic [TW-1:0] s2);
    bus.dispatchValid_i = 1; bus.dispatchCommands_i = 10'(tag) ^ 10'h2A5;
    bus.dispatchTag_i = tag;
    bus.dispatchVal1_i = v1; bus.dispatchRdy1_i = r1; bus.dispatchSrc1_i = s1;
    bus.dispatchVal2_i = v2; bus.dispatchRdy2_i = r2; bus.dispatchSrc2_i = s2;
  endtask

  task automatic cdb(input logic [TW-1:0] tag, input logic [63:0] val);
    bus.cdbValid_i = 1; bus.cdbTag_i = tag; bus.cdbVal_i = val;
  endtask

  initial begin
    rst = 1;
    idle(0);
    @(negedge clk);
    step(); step();
    rst = 0;
    idle(0); #1;
    chk("reset_ready", bus.readyRS_o, 0);
    chk("reset_full", bus.full_o, 0);
    step();

    // 1: ready dispatch, one-cycle latency, issued at once.
    disp(3, 6, 1, 0, 7, 1, 0); step();
    idle(0); #1;
    chk("t1_ready", bus.readyRS_o, 1);
    chk("t1_val1", bus.reservationStationVal1_o, 6);
    chk("t1_val2", bus.reservationStationVal2_o, 7);
    chk("t1_tag", bus.reservationStationTag_o, 3);
    step();
    #1; chk("t1_gone", bus.readyRS_o, 0); step();

    // 2: wakeup from CDB two cycles after dispatch.
    disp(4, 0, 0, 9, 1, 1, 0); step();
    idle(0); step();
    cdb(9, 64'h55); step();
    idle(0); #1;
    chk("t2_ready", bus.readyRS_o, 1);
    chk("t2_val1", bus.reservationStationVal1_o, 64'h55);
    step();

    // 3: CDB in the dispatch cycle.
    disp(8, 2, 1, 0, 0, 0, 2); cdb(2, 64'hAA); step();
    idle(0); #1;
    chk("t3_ready", bus.readyRS_o, 1);
    chk("t3_val2", bus.reservationStationVal2_o, 64'hAA);
    step();

    // 4: fill under stall, extra dispatch ignored, selection held.
    for (int i = 0; i < N; i++) begin
      idle(1); disp(5'(10 + i), 64'(i), 1, 0, 64'(i + 1), 1, 0); step();
    end
    idle(1); #1; chk("t4_full", bus.full_o, 1);
    disp(14, 1, 1, 0, 1, 1, 0); step();
    for (int i = 0; i < 10; i++) begin
      idle(1); #1; chk("t4_hold", bus.reservationStationTag_o, 10); step();
    end
    for (int i = 0; i < N + 1; i++) begin idle(0); step(); end
    #1; chk("t4_drained", bus.readyRS_o, 0);

    // 5: 5 and 7 wake together; 6 waits on another tag.
    idle(0); disp(5, 0, 0, 20, 1, 1, 0); step();
    idle(0); disp(6, 0, 0, 21, 1, 1, 0); step();
    idle(0); disp(7, 0, 0, 20, 1, 1, 0); step();
    idle(0); cdb(20, 64'h77); step();
    idle(0); #1; chk("t5_first", bus.reservationStationTag_o, 5); step();
    #1; chk("t5_second", bus.reservationStationTag_o, 7); step();
    cdb(21, 64'h88); step();
    idle(0); #1; chk("t5_third", bus.reservationStationTag_o, 6); step();

    // 6: reset with busy entries; CDB/dispatch in reset cycle ignored.
    for (int i = 0; i < 3; i++) begin
      idle(1); disp(5'(16 + i), 1, 1, 0, 2, 1, 0); step();
    end
    idle(1); disp(19, 0, 0, 3, 0, 0, 3); step();
    idle(1); #1; chk("t6_pre_ready", bus.readyRS_o, 1);
    rst = 1; disp(20, 1, 1, 0, 1, 1, 0); cdb(3, 64'h99); step();
    rst = 0; idle(0); #1;
    chk("t6_ready", bus.readyRS_o, 0);
    chk("t6_full", bus.full_o, 0);
    chk("t6_val1", bus.reservationStationVal1_o, 0);
    step();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      idle($urandom_range(0, 9) < 4);
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) < 6)
        disp(5'($urandom_range(0, 31)), {$urandom, $urandom}, 1'($urandom),
             5'($urandom_range(0, 7)), {$urandom, $urandom}, 1'($urandom),
             5'($urandom_range(0, 7)));
      if ($urandom_range(0, 1) == 1)
        cdb(5'($urandom_range(0, 7)), {$urandom, $urandom});
      step();
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
